instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 arst_n  input  1  asynchronous active-low reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  word address of the request, bits [1:0] always 0.
REQ-006 imem_gnt  input  1  memory accepts the request this cycle.
REQ-007 imem_rvalid  input  1  response data valid.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 redirect_valid  input  1  branch taken; restart fetch at redirect_pc.
REQ-010 redirect_pc  input  32  branch target.
REQ-011 instr_valid  output  1  instr/pc/instr_type are valid for the decode stage.
REQ-012 id_ready  input  1  decode stage accepts the instruction.
REQ-013 instr  output  32  registered instruction word.
REQ-014 instr_pc  output  32  address of instr.
REQ-015 instr_type  output  instr_type_t  opcode class driving the instruction decoder.
REQ-016 illegal_instr  output  1  unsupported opcode flag.

Function
REQ-017 The FSM SHALL have states FETCH, WAIT, HOLD, and HALT (HALT only with FETCH_ILLEGAL_TRAP_EN).
- FETCH: imem_req=1, imem_addr=pc; on imem_gnt: pc<=pc+4 (mod 2^32), go WAIT.
- WAIT: on imem_rvalid: capture instr, instr_pc, classification; instr_valid<=1; go HOLD.
- HOLD: hold outputs stable while id_ready=0; on id_ready: instr_valid<=0, go FETCH.
REQ-018 Classification SHALL use instr[6:0]: 0110011->R_TYPE, 0000011->I_TYPE_LOAD, 0010011->I_TYPE_ALU, 1100011->B_TYPE, 0100011->S_TYPE; any other opcode is unsupported.
REQ-019 The handshake SHALL transfer an instruction exactly on a cycle with instr_valid=1 and id_ready=1; each fetched word SHALL be presented exactly once.
REQ-020 Redirect SHALL have priority over all other events: pc<={redirect_pc[31:2],2'b00}, instr_valid<=0 next cycle, next state FETCH.
REQ-021 A redirect in WAIT, or in FETCH coinciding with imem_gnt, SHALL set a drop flag; the next imem_rvalid SHALL be discarded, with no instr_valid.
REQ-022 The block SHALL wait in FETCH while the drop flag is set, and keep imem_req=0 until the discarded response arrives.
REQ-023 imem_rvalid outside WAIT without the drop flag SHALL be ignored.
REQ-024 Minimum latency SHALL be: gnt cycle -> rvalid cycle -> instr_valid asserted the following cycle.
REQ-025 Throughput SHALL be at most one instruction per 3 cycles; no prefetch.

Reset
REQ-026 While arst_n=0, outputs SHALL be: pc=RESET_PC, state=FETCH, drop flag=0, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_type=I_TYPE_ALU, illegal_instr=0, imem_req=0.
REQ-027 imem_req SHALL assert no earlier than the first rising edge after arst_n deasserts.
REQ-028 Reset asserted mid-transaction SHALL abandon it; a late rvalid after reset SHALL be ignored per REQ-023.

Configuration
REQ-029 With FETCH_ILLEGAL_TRAP_EN defined:
- an unsupported opcode SHALL be presented with illegal_instr=1 and instr_type=S_TYPE;
- after handshake, the FSM SHALL enter HALT (imem_req=0, instr_valid=0) until reset or redirect.
REQ-030 Without FETCH_ILLEGAL_TRAP_EN, illegal_instr SHALL be tied 0, HALT SHALL not exist, and unsupported opcodes SHALL pass as S_TYPE.

Structure
REQ-031 instr_type_t (R_TYPE, I_TYPE_LOAD, I_TYPE_ALU, B_TYPE, S_TYPE), the opcode constants and the NOP constant SHALL live in rv32i_pkg.
REQ-032 Opcode classification SHALL be the combinational sub-module opcode_class; the FSM, PC and output register remain in instr_fetch.

Verification
REQ-033 Reset with RESET_PC=0x100, gnt=1, rvalid one cycle later -> imem_addr=0x100, then 0x104; instr_pc=0x100.
REQ-034 rdata=0x00A00093 (addi) with id_ready=0 for 5 cycles -> instr_valid held, outputs stable, instr_type=I_TYPE_ALU, no new imem_req.
REQ-035 redirect_valid with redirect_pc=0x203 during WAIT -> following rvalid dropped, next imem_addr=0x200, no instr_valid for the dropped word.
REQ-036 Sequence 0x00000033, 0x00002003, 0x00002023, 0x00000063 -> R_TYPE, I_TYPE_LOAD, S_TYPE, B_TYPE in order, each handshaken once.
REQ-037 With FETCH_ILLEGAL_TRAP_EN, rdata=0x0000007F -> illegal_instr=1, then HALT with imem_req=0; redirect to 0x40 resumes fetch at 0x40.
REQ-038 Fetch at pc=0xFFFFFFFC -> next imem_addr=0x00000000; arst_n low during WAIT -> imem_req=0, instr_valid=0 immediately.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the fetch stage: opcode classes, major opcodes and the NOP word.
package rv32i_pkg;

  typedef enum logic [2:0] {
    R_TYPE      = 3'd0,
    I_TYPE_LOAD = 3'd1,
    I_TYPE_ALU  = 3'd2,
    B_TYPE      = 3'd3,
    S_TYPE      = 3'd4
  } instr_type_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier: maps instr[6:0] onto the decoder's instruction class.
// Unknown opcodes report S_TYPE together with unsupported_o.
import rv32i_pkg::*;

module opcode_class (
  input  logic [6:0]  opcode_i,
  output instr_type_t type_o,
  output logic        unsupported_o
);

  always_comb begin
    type_o        = S_TYPE;
    unsupported_o = 1'b0;
    case (opcode_i)
      OPC_OP:     type_o = R_TYPE;
      OPC_LOAD:   type_o = I_TYPE_LOAD;
      OPC_OP_IMM: type_o = I_TYPE_ALU;
      OPC_BRANCH: type_o = B_TYPE;
      OPC_STORE:  type_o = S_TYPE;
      default:    unsupported_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Non-prefetching instruction fetch stage: FETCH -> WAIT -> HOLD, one word in flight, redirect-aware.
// Optional FETCH_ILLEGAL_TRAP_EN flags unsupported opcodes and halts fetch after their handshake.
import rv32i_pkg::*;

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        arst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        id_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output instr_type_t instr_type,
  output logic        illegal_instr
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
`ifdef FETCH_ILLEGAL_TRAP_EN
  localparam logic [1:0] ST_HALT  = 2'd3;
  localparam logic       TRAP_EN  = 1'b1;
`else
  localparam logic       TRAP_EN  = 1'b0;
`endif

  localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        req_en_q;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  instr_type_t type_q, type_d;
  logic        illegal_q, illegal_d;

  instr_type_t cls_type;
  logic        cls_unsup;
  logic        fire;

  opcode_class u_opcode_class (
    .opcode_i      (imem_rdata[6:0]),
    .type_o        (cls_type),
    .unsupported_o (cls_unsup)
  );

  // req_en_q keeps the request low until the first edge after reset release.
  assign imem_req      = req_en_q && (state_q == ST_FETCH) && !drop_q;
  assign imem_addr     = pc_q;
  assign fire          = imem_req && imem_gnt;
  assign instr_valid   = valid_q;
  assign instr         = instr_q;
  assign instr_pc      = instr_pc_q;
  assign instr_type    = type_q;
  assign illegal_instr = illegal_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    type_d     = type_q;
    illegal_d  = illegal_q;
    // Any response arriving while a drop is pending is the stale one.
    drop_d     = drop_q && !imem_rvalid;

    if (redirect_valid) begin
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      valid_d = 1'b0;
      state_d = ST_FETCH;
      // A word is still in flight unless it is returning right now.
      if (fire || ((state_q == ST_WAIT) && !imem_rvalid)) begin
        drop_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (fire) begin
            pc_d    = pc_q + 32'd4;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q - 32'd4;
            type_d     = cls_type;
            illegal_d  = TRAP_EN & cls_unsup;
            valid_d    = 1'b1;
            state_d    = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (id_ready) begin
            valid_d = 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
            state_d = illegal_q ? ST_HALT : ST_FETCH;
`else
            state_d = ST_FETCH;
`endif
          end
        end
`ifdef FETCH_ILLEGAL_TRAP_EN
        ST_HALT: state_d = ST_HALT;
`endif
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= PC_INIT;
      drop_q     <= 1'b0;
      req_en_q   <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC;
      type_q     <= I_TYPE_ALU;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      req_en_q   <= 1'b1;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      type_q     <= type_d;
      illegal_q  <= illegal_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by a randomized run,
// checked against a transaction-level model of the fetch stream and a memory responder.
module tb_instr_fetch;
  import rv32i_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef FETCH_ILLEGAL_TRAP_EN
  localparam bit TRAP_BUILD = 1'b1;
`else
  localparam bit TRAP_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        id_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  instr_type_t instr_type;
  logic        illegal_instr;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .id_ready       (id_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_type     (instr_type),
    .illegal_instr  (illegal_instr)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } txn_t;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;

  // environment knobs
  int gnt_pct = 100, lat_min = 1, lat_max = 1, rdy_pct = 100, redir_pct = 0, stray_pct = 0;
  bit          redir_req = 1'b0;
  logic [31:0] redir_tgt = 32'h0;

  // reference model state
  txn_t        outq[$];
  logic [31:0] mem_ovr[int unsigned];
  logic [31:0] exp_pc = RST_PC;
  int          nhs = 0;
  int          gnt_cyc = 0;
  logic [31:0] gnt_log[$];
  logic [31:0] pc_log[$];
  instr_type_t type_log[$];
  bit          prev_hold = 0, prev_redir = 0, prev_hs = 0;
  logic [31:0] prev_instr = 0, prev_pc = 0;
  instr_type_t prev_type = I_TYPE_ALU;
  bit          valid_now = 0, gnt_now = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  opc;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    h = (a ^ 32'h5BD1_E995) * 32'h9E37_79B1;
    case (h[31:29])
      3'd0: opc = 7'b0110011;
      3'd1: opc = 7'b0000011;
      3'd2: opc = 7'b0010011;
      3'd3: opc = 7'b1100011;
      3'd4: opc = 7'b0100011;
      3'd5: opc = TRAP_BUILD ? 7'b0010011 : 7'b1101111;
      3'd6: opc = TRAP_BUILD ? 7'b0000011 : 7'b0110111;
      default: opc = 7'b0010011;
    endcase
    return {h[24:0], opc};
  endfunction

  function automatic instr_type_t exp_type(input logic [31:0] w);
    case (w[6:0])
      7'b0110011: return R_TYPE;
      7'b0000011: return I_TYPE_LOAD;
      7'b0010011: return I_TYPE_ALU;
      7'b1100011: return B_TYPE;
      default:    return S_TYPE;
    endcase
  endfunction

  function automatic bit exp_illegal(input logic [31:0] w);
    return TRAP_BUILD &&
           !(w[6:0] inside {7'b0110011, 7'b0000011, 7'b0010011, 7'b1100011, 7'b0100011});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit   hs;
    txn_t t;
    @(negedge clk);
    cyc++;
    valid_now = instr_valid;
    if (prev_redir || prev_hs) begin
      chk("valid_drop", 32'(instr_valid), 32'd0);
    end else if (prev_hold) begin
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_instr", instr, prev_instr);
      chk("hold_pc", instr_pc, prev_pc);
      chk("hold_type", 32'(instr_type), 32'(prev_type));
    end
    if (imem_req) begin
      chk("req_addr", imem_addr, exp_pc);
      chk("req_idle", 32'(outq.size()), 32'd0);
      chk("req_novalid", 32'(instr_valid), 32'd0);
    end
    if (instr_valid) begin
      chk("pres_pc", instr_pc, exp_pc);
      chk("pres_instr", instr, mem_word(exp_pc));
      chk("pres_type", 32'(instr_type), 32'(exp_type(mem_word(exp_pc))));
      chk("pres_illegal", 32'(illegal_instr), 32'(exp_illegal(mem_word(exp_pc))));
    end

    imem_gnt = (int'($urandom_range(99)) < gnt_pct);
    if (outq.size() > 0 && outq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(outq[0].addr);
      void'(outq.pop_front());
    end else if (outq.size() == 0 && int'($urandom_range(99)) < stray_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    id_ready       = (int'($urandom_range(99)) < rdy_pct);
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (redir_req) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_tgt;
      redir_req      = 1'b0;
    end else if (!imem_rvalid && int'($urandom_range(99)) < redir_pct) begin
      redirect_valid = 1'b1;
    end
    if (redirect_valid) id_ready = 1'b0;

    hs      = instr_valid && id_ready && !redirect_valid;
    gnt_now = imem_req && imem_gnt;
    if (gnt_now) begin
      t.addr = imem_addr;
      t.due  = cyc + int'($urandom_range(lat_max, lat_min));
      outq.push_back(t);
      gnt_log.push_back(imem_addr);
      gnt_cyc = cyc;
    end
    if (redirect_valid) begin
      exp_pc = redirect_pc & 32'hFFFF_FFFC;
    end else if (hs) begin
      exp_pc = exp_pc + 32'd4;
      nhs++;
      pc_log.push_back(instr_pc);
      type_log.push_back(instr_type);
    end
    prev_hs    = hs;
    prev_redir = redirect_valid;
    prev_hold  = instr_valid && !id_ready && !redirect_valid;
    prev_instr = instr;
    prev_pc    = instr_pc;
    prev_type  = instr_type;
  endtask

  task automatic do_reset(input bit late_rvalid);
    #2 arst_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, NOP_INSTR);
    chk("rst_pc", instr_pc, RST_PC);
    chk("rst_type", 32'(instr_type), 32'(I_TYPE_ALU));
    chk("rst_illegal", 32'(illegal_instr), 32'd0);
    imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_req", 32'(imem_req), 32'd0);
    chk("rst_hold_addr", imem_addr, RST_PC);
    arst_n      = 1'b1;
    imem_gnt    = 1'b1;
    imem_rvalid = late_rvalid;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    chk("rst_exit_req", 32'(imem_req), 32'd0);
    outq.delete(); mem_ovr.delete(); gnt_log.delete(); pc_log.delete(); type_log.delete();
    exp_pc = RST_PC; nhs = 0;
    prev_hold = 0; prev_redir = 0; prev_hs = 0;
    redir_req = 0;
  endtask

  task automatic run_until_valid(input int max, input string tag);
    int n = 0;
    do begin cycle(); n++; end while (!valid_now && n < max);
    chk({tag, "_valid_timeout"}, 32'(valid_now), 32'd1);
  endtask

  task automatic run_until_gnt(input int max, input string tag);
    int n = 0;
    do begin cycle(); n++; end while (!gnt_now && n < max);
    chk({tag, "_gnt_timeout"}, 32'(gnt_now), 32'd1);
  endtask

  initial begin
    int nv;
    int n;
    @(negedge clk);

    // reset release, first two fetch addresses, minimum latency
    do_reset(1'b0);
    gnt_pct = 100; lat_min = 1; lat_max = 1; rdy_pct = 100;
    run_until_valid(10, "t1");
    chk("t1_latency", 32'(cyc - gnt_cyc), 32'd2);
    run_until_gnt(6, "t1b");
    chk("t1_addr0", gnt_log[0], 32'h100);
    chk("t1_addr1", gnt_log[1], 32'h104);
    chk("t1_pc0", pc_log[0], 32'h100);

    // decode stall: held outputs and no new request
    do_reset(1'b0);
    mem_ovr[RST_PC] = 32'h00A0_0093;
    rdy_pct = 0;
    run_until_valid(10, "t2");
    chk("t2_type", 32'(instr_type), 32'(I_TYPE_ALU));
    chk("t2_instr", instr, 32'h00A0_0093);
    repeat (5) begin
      cycle();
      chk("t2_held", 32'(valid_now), 32'd1);
      chk("t2_noreq", 32'(imem_req), 32'd0);
    end
    rdy_pct = 100;
    cycle();
    chk("t2_one_hs", 32'(nhs), 32'd1);

    // redirect during WAIT drops the in-flight word
    do_reset(1'b0);
    lat_min = 2; lat_max = 2;
    run_until_gnt(5, "t3");
    redir_req = 1'b1; redir_tgt = 32'h203;
    nv = 0; n = 0;
    do begin cycle(); if (valid_now) nv++; n++; end while (!gnt_now && n < 12);
    chk("t3_no_valid", 32'(nv), 32'd0);
    chk("t3_addr", gnt_log[gnt_log.size() - 1], 32'h200);
    run_until_valid(10, "t3c");
    chk("t3_pc", instr_pc, 32'h200);

    // classification sequence with a hesitant decoder
    do_reset(1'b0);
    lat_min = 1; lat_max = 1; rdy_pct = 50;
    mem_ovr[32'h100] = 32'h0000_0033;
    mem_ovr[32'h104] = 32'h0000_2003;
    mem_ovr[32'h108] = 32'h0000_2023;
    mem_ovr[32'h10C] = 32'h0000_0063;
    n = 0;
    while (nhs < 4 && n < 200) begin cycle(); n++; end
    chk("t4_count", 32'(nhs), 32'd4);
    chk("t4_type0", 32'(type_log[0]), 32'(R_TYPE));
    chk("t4_type1", 32'(type_log[1]), 32'(I_TYPE_LOAD));
    chk("t4_type2", 32'(type_log[2]), 32'(S_TYPE));
    chk("t4_type3", 32'(type_log[3]), 32'(B_TYPE));
    for (int i = 0; i < 4; i++) chk("t4_pc", pc_log[i], 32'h100 + 32'(4 * i));

    // PC wrap-around
    do_reset(1'b0);
    rdy_pct = 100; gnt_pct = 0;
    redir_req = 1'b1; redir_tgt = 32'hFFFF_FFFC;
    cycle();
    gnt_pct = 100;
    n = 0;
    while (gnt_log.size() < 2 && n < 15) begin cycle(); n++; end
    chk("t5_addr0", gnt_log[0], 32'hFFFF_FFFC);
    chk("t5_addr1", gnt_log[1], 32'h0000_0000);
    chk("t5_pc0", pc_log[0], 32'hFFFF_FFFC);

    // reset in WAIT with a late response, then reset in HOLD
    do_reset(1'b0);
    lat_min = 3; lat_max = 3;
    run_until_gnt(5, "t6");
    cycle();
    do_reset(1'b1);
    lat_min = 1; lat_max = 1;
    run_until_valid(10, "t6b");
    chk("t6_pc", instr_pc, RST_PC);
    rdy_pct = 0;
    run_until_valid(10, "t6c");
    do_reset(1'b0);

`ifdef FETCH_ILLEGAL_TRAP_EN
    // unsupported opcode halts fetch until redirect
    mem_ovr[RST_PC] = 32'h0000_007F;
    rdy_pct = 0;
    run_until_valid(10, "t7");
    chk("t7_illegal", 32'(illegal_instr), 32'd1);
    chk("t7_type", 32'(instr_type), 32'(S_TYPE));
    rdy_pct = 100;
    cycle();
    repeat (4) begin
      cycle();
      chk("t7_halt_req", 32'(imem_req), 32'd0);
      chk("t7_halt_valid", 32'(instr_valid), 32'd0);
    end
    redir_req = 1'b1; redir_tgt = 32'h40;
    cycle();
    run_until_gnt(5, "t7b");
    chk("t7_resume", gnt_log[gnt_log.size() - 1], 32'h40);
    do_reset(1'b0);
`endif

    // randomized traffic
    gnt_pct = 70; lat_min = 1; lat_max = 4; rdy_pct = 60; redir_pct = 3; stray_pct = 5;
    repeat (3000) cycle();
    chk("rand_progress", 32'(nhs >= 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
